// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction-queue entry layout and pointer-width helper.
package cpu_defs_pkg;
    localparam int IQ_PC_W = 32;

    typedef struct packed {
        logic [IQ_PC_W-1:0] pc;
        logic [IQ_PC_W-1:0] instr;
        logic               ds;
    } iq_entry_t;

    localparam iq_entry_t NOP_ENTRY = '0;

    function automatic int IQ_PTR_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/iq_storage.sv
// Un-reset entry array for the fetch/decode queue: two write ports, head/head+1
// read ports for decode, and one extra read port for the delay-slot candidate.
module iq_storage
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = IQ_PTR_W(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we0,
    input  logic [PW-1:0] i_waddr0,
    input  iq_entry_t     i_wdata0,
    input  logic          i_we1,
    input  logic [PW-1:0] i_waddr1,
    input  iq_entry_t     i_wdata1,
    input  logic [PW-1:0] i_raddr0,
    input  logic [PW-1:0] i_raddr1,
    input  logic [PW-1:0] i_raddr_c,
    output iq_entry_t     o_rdata0,
    output iq_entry_t     o_rdata1,
    output iq_entry_t     o_rdata_c
);
    iq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_waddr0] <= i_wdata0;
        if (i_we1) r_mem[i_waddr1] <= i_wdata1;
    end

    assign o_rdata0  = r_mem[i_raddr0];
    assign o_rdata1  = r_mem[i_raddr1];
    assign o_rdata_c = r_mem[i_raddr_c];
endmodule

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and a dual-issue decoder, with full
// flush and delay-slot-preserving flush. PC_W must match the package entry width.
module fetch_decode_queue
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = IQ_PC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   flush_keep_ds,
    input  logic [1:0]             in_num,
    input  logic [PC_W-1:0]        in_pc0,
    input  logic [PC_W-1:0]        in_pc1,
    input  logic [PC_W-1:0]        in_instr0,
    input  logic [PC_W-1:0]        in_instr1,
    input  logic                   in_ds0,
    input  logic                   in_ds1,
    output logic                   in_ready,
    output logic [1:0]             out_valid,
    output logic [PC_W-1:0]        out_pc0,
    output logic [PC_W-1:0]        out_pc1,
    output logic [PC_W-1:0]        out_pcplus4_0,
    output logic [PC_W-1:0]        out_pcplus4_1,
    output logic [PC_W-1:0]        out_instr0,
    output logic [PC_W-1:0]        out_instr1,
    output logic                   out_ds0,
    output logic                   out_ds1,
    input  logic [1:0]             pop_num,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = IQ_PTR_W(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic [1:0]    w_push_n, w_pop_req, w_pop_n;
    logic [PW-1:0] w_cand_addr;
    logic          w_cand_exists, w_keep_old, w_keep_new;
    iq_entry_t     w_in0, w_in1, w_rd0, w_rd1, w_rd_c;
    logic          w_we0, w_we1;
    logic [PW-1:0] w_waddr0, w_waddr1;
    iq_entry_t     w_wdata0, w_wdata1;

    // Registered count only: a same-cycle pop never opens room for a push.
    assign w_in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_push_n   = !w_in_ready ? 2'd0 : ((in_num == 2'd3) ? 2'd2 : in_num);
    assign w_pop_req  = (pop_num == 2'd3) ? 2'd2 : pop_num;
    assign w_pop_n    = (CW'(w_pop_req) > r_count) ? r_count[1:0] : w_pop_req;

    assign w_cand_addr   = r_head + PW'(w_pop_n);
    assign w_cand_exists = (r_count > CW'(w_pop_n));
    assign w_keep_old    = flush && flush_keep_ds && w_cand_exists;
    assign w_keep_new    = flush && flush_keep_ds && !w_cand_exists && (w_push_n != 2'd0);

    assign w_in0 = '{pc: in_pc0, instr: in_instr0, ds: in_ds0};
    assign w_in1 = '{pc: in_pc1, instr: in_instr1, ds: in_ds1};

    always_comb begin
        w_we0    = 1'b0;
        w_we1    = 1'b0;
        w_waddr0 = r_tail;
        w_waddr1 = r_tail + PW'(1);
        w_wdata0 = w_in0;
        w_wdata1 = w_in1;
        if (rst) begin
            w_we0 = 1'b0;
        end else if (flush) begin
            // Surviving delay slot is relocated to index 0 and marked as such.
            if (w_keep_old || w_keep_new) begin
                w_we0       = 1'b1;
                w_waddr0    = '0;
                w_wdata0    = w_keep_old ? w_rd_c : w_in0;
                w_wdata0.ds = 1'b1;
            end
        end else begin
            w_we0 = (w_push_n != 2'd0);
            w_we1 = (w_push_n == 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head <= '0;
            if (w_keep_old || w_keep_new) begin
                r_tail  <= PW'(1);
                r_count <= CW'(1);
            end else begin
                r_tail  <= '0;
                r_count <= '0;
            end
        end else begin
            r_head  <= r_head + PW'(w_pop_n);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count - CW'(w_pop_n) + CW'(w_push_n);
        end
    end

    iq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk       (clk),
        .i_we0     (w_we0),
        .i_waddr0  (w_waddr0),
        .i_wdata0  (w_wdata0),
        .i_we1     (w_we1),
        .i_waddr1  (w_waddr1),
        .i_wdata1  (w_wdata1),
        .i_raddr0  (r_head),
        .i_raddr1  (r_head + PW'(1)),
        .i_raddr_c (w_cand_addr),
        .o_rdata0  (w_rd0),
        .o_rdata1  (w_rd1),
        .o_rdata_c (w_rd_c)
    );

    assign in_ready     = w_in_ready;
    assign count        = r_count;
    assign out_valid[0] = (r_count >= CW'(1));
    assign out_valid[1] = (r_count >= CW'(2));

    // Invalid slots present a NOP at PC 0, including the pc+4 field.
    assign out_pc0       = out_valid[0] ? w_rd0.pc           : '0;
    assign out_instr0    = out_valid[0] ? w_rd0.instr        : '0;
    assign out_ds0       = out_valid[0] ? w_rd0.ds           : 1'b0;
    assign out_pcplus4_0 = out_valid[0] ? w_rd0.pc + PC_W'(4) : '0;
    assign out_pc1       = out_valid[1] ? w_rd1.pc           : '0;
    assign out_instr1    = out_valid[1] ? w_rd1.instr        : '0;
    assign out_ds1       = out_valid[1] ? w_rd1.ds           : 1'b0;
    assign out_pcplus4_1 = out_valid[1] ? w_rd1.pc + PC_W'(4) : '0;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed table-driven bench for fetch_decode_queue at DEPTH=8, PC_W=32.
module tb_fetch_decode_queue;
    logic        clk = 1'b0;
    logic        rst, flush, flush_keep_ds;
    logic [1:0]  in_num, pop_num;
    logic [31:0] in_pc0, in_pc1, in_instr0, in_instr1;
    logic        in_ds0, in_ds1;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0, out_pc1, out_pcplus4_0, out_pcplus4_1, out_instr0, out_instr1;
    logic        out_ds0, out_ds1;
    logic [3:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_decode_queue #(.DEPTH(8), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_keep_ds(flush_keep_ds),
        .in_num(in_num), .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_instr0(in_instr0), .in_instr1(in_instr1),
        .in_ds0(in_ds0), .in_ds1(in_ds1), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_pcplus4_0(out_pcplus4_0), .out_pcplus4_1(out_pcplus4_1),
        .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_ds0(out_ds0), .out_ds1(out_ds1), .pop_num(pop_num), .count(count)
    );

    typedef struct {
        logic [1:0]  in_num;
        logic [31:0] pc0, pc1;
        logic [1:0]  pop;
        logic        fl, keep;
        logic [3:0]  e_cnt;
        logic [1:0]  e_vld;
        logic [31:0] e_pc0, e_pc1;
        logic        e_ds0, e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] n, logic [31:0] p0, logic [31:0] p1, logic [1:0] pop,
                                logic fl, logic keep, logic [3:0] c, logic [1:0] v,
                                logic [31:0] e0, logic [31:0] e1, logic ds0, logic rdy);
        vec_t t;
        t.in_num = n; t.pc0 = p0; t.pc1 = p1; t.pop = pop; t.fl = fl; t.keep = keep;
        t.e_cnt = c; t.e_vld = v; t.e_pc0 = e0; t.e_pc1 = e1; t.e_ds0 = ds0; t.e_rdy = rdy;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    // Full output check; instr is always ~pc in this bench, pc+4 and data are 0 when invalid.
    task automatic chk_all(input int idx, input logic [3:0] c, input logic [1:0] v,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic ds0, input logic ds1, input logic rdy);
        chk("count",     idx, 32'(count), 32'(c));
        chk("out_valid", idx, 32'(out_valid), 32'(v));
        chk("in_ready",  idx, 32'(in_ready), 32'(rdy));
        chk("out_pc0",   idx, out_pc0, v[0] ? e0 : 32'h0);
        chk("out_pc1",   idx, out_pc1, v[1] ? e1 : 32'h0);
        chk("out_instr0", idx, out_instr0, v[0] ? ~e0 : 32'h0);
        chk("out_instr1", idx, out_instr1, v[1] ? ~e1 : 32'h0);
        chk("out_pcplus4_0", idx, out_pcplus4_0, v[0] ? e0 + 32'd4 : 32'h0);
        chk("out_pcplus4_1", idx, out_pcplus4_1, v[1] ? e1 + 32'd4 : 32'h0);
        chk("out_ds0",   idx, 32'(out_ds0), 32'(v[0] & ds0));
        chk("out_ds1",   idx, 32'(out_ds1), 32'(v[1] & ds1));
    endtask

    task automatic drive(input logic [1:0] n, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] pop, input logic fl, input logic keep);
        in_num = n; in_pc0 = p0; in_pc1 = p1; in_instr0 = ~p0; in_instr1 = ~p1;
        pop_num = pop; flush = fl; flush_keep_ds = keep;
    endtask

    localparam logic [31:0] B = 32'hBFC0_0000;
    localparam logic [31:0] D = 32'h8000_2000;

    initial begin
        logic [31:0] p;
        rst = 1'b1; in_ds0 = 1'b0; in_ds1 = 1'b0;
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);

        // Fill to full, overflow attempts, drain with clipped pop.
        vecs.push_back(mk(2, B,       B+32'h04, 0, 0, 0, 2, 2'b11, B,       B+32'h04, 0, 1));
        vecs.push_back(mk(2, B+32'h08, B+32'h0C, 0, 0, 0, 4, 2'b11, B,       B+32'h04, 0, 1));
        vecs.push_back(mk(2, B+32'h10, B+32'h14, 0, 0, 0, 6, 2'b11, B,       B+32'h04, 0, 1));
        vecs.push_back(mk(2, B+32'h18, B+32'h1C, 0, 0, 0, 8, 2'b11, B,       B+32'h04, 0, 0));
        vecs.push_back(mk(2, B+32'h20, B+32'h24, 0, 0, 0, 8, 2'b11, B,       B+32'h04, 0, 0));
        vecs.push_back(mk(2, B+32'h20, B+32'h24, 2, 0, 0, 6, 2'b11, B+32'h08, B+32'h0C, 0, 1));
        vecs.push_back(mk(1, B+32'h20, B+32'h24, 0, 0, 0, 7, 2'b11, B+32'h08, B+32'h0C, 0, 0));
        vecs.push_back(mk(2, B+32'h28, B+32'h2C, 2, 0, 0, 5, 2'b11, B+32'h10, B+32'h14, 0, 1));
        vecs.push_back(mk(0, 0, 0,               2, 0, 0, 3, 2'b11, B+32'h18, B+32'h1C, 0, 1));
        vecs.push_back(mk(0, 0, 0,               2, 0, 0, 1, 2'b01, B+32'h20, 0,        0, 1));
        vecs.push_back(mk(0, 0, 0,               2, 0, 0, 0, 2'b00, 0,        0,        0, 1));
        // Alternating push-2 / pop-2 pairs across the index 7 -> 0 boundary.
        for (int k = 0; k < 5; k++) begin
            p = 32'h8000_1000 + 32'(16 * k);
            vecs.push_back(mk(2, p, p+32'h4, 0, 0, 0, 2, 2'b11, p, p+32'h4, 0, 1));
            vecs.push_back(mk(0, 0, 0,       2, 0, 0, 0, 2'b00, 0, 0,       0, 1));
        end
        // Delay-slot flushes: surviving entry, candidate at head+2, push slot, nothing.
        vecs.push_back(mk(2, D,       D+32'h04, 0, 0, 0, 2, 2'b11, D,       D+32'h04, 0, 1));
        vecs.push_back(mk(2, D+32'h08, D+32'h0C, 0, 0, 0, 4, 2'b11, D,       D+32'h04, 0, 1));
        vecs.push_back(mk(0, 0, 0,               1, 1, 1, 1, 2'b01, D+32'h04, 0,        1, 1));
        vecs.push_back(mk(2, D+32'h10, D+32'h14, 0, 0, 0, 3, 2'b11, D+32'h04, D+32'h10, 1, 1));
        vecs.push_back(mk(0, 0, 0,               2, 1, 1, 1, 2'b01, D+32'h14, 0,        1, 1));
        vecs.push_back(mk(2, D+32'h20, D+32'h24, 1, 1, 1, 1, 2'b01, D+32'h20, 0,        1, 1));
        vecs.push_back(mk(0, 0, 0,               1, 1, 1, 0, 2'b00, 0,        0,        0, 1));
        vecs.push_back(mk(2, D+32'h30, D+32'h34, 0, 0, 0, 2, 2'b11, D+32'h30, D+32'h34, 0, 1));
        vecs.push_back(mk(2, D+32'h40, D+32'h44, 1, 1, 0, 0, 2'b00, 0,        0,        0, 1));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all(-1, 4'd0, 2'b00, 0, 0, 0, 0, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].in_num, vecs[i].pc0, vecs[i].pc1, vecs[i].pop, vecs[i].fl, vecs[i].keep);
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].e_cnt, vecs[i].e_vld, vecs[i].e_pc0, vecs[i].e_pc1,
                    vecs[i].e_ds0, 1'b0, vecs[i].e_rdy);
        end

        // Incoming ds flags pass through untouched.
        drive(2'd2, 32'h0000_0100, 32'h0000_0104, 2'd0, 1'b0, 1'b0);
        in_ds0 = 1'b0; in_ds1 = 1'b1;
        @(posedge clk); #1;
        chk_all(100, 4'd2, 2'b11, 32'h100, 32'h104, 1'b0, 1'b1, 1'b1);
        in_ds1 = 1'b0;

        // rst beats flush, push and pop in the same cycle.
        drive(2'd2, 32'h0000_0200, 32'h0000_0204, 2'd1, 1'b1, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        chk_all(101, 4'd0, 2'b00, 0, 0, 0, 0, 1'b1);

        // Queue is usable again after the mid-operation reset.
        drive(2'd1, 32'h0000_0300, 32'h0, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        chk_all(102, 4'd1, 2'b01, 32'h300, 0, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
